// File: rtl/flag_pipe_unit.sv
// Two-stage condition-flag pipeline: stage 1 registers sliced zero-detect and raw ALU
// status bits, stage 2 reduces them and commits {N,Z,V,C} into the architectural flags.
module flag_pipe_unit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             overflow_in,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       flags,
    output logic             flags_update
);

    localparam int NCHUNK = WIDTH / CHUNK;

    // in_valid qualifies result/carry_in/overflow_in/set_flags for one cycle; there is no
    // backpressure, so while stall is high the upstream must not expect in_valid to be taken.
    logic [NCHUNK-1:0] slice_zero;
    logic [NCHUNK-1:0] zero1;
    logic              msb1;
    logic              carry1;
    logic              ovf1;
    logic              valid1;
    logic              set1;

    logic              z_flag;
    logic [3:0]        next_flags;
    logic              commit;

    // Each slice is a narrow NOR so the full-width zero test splits across the register.
    for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
        assign slice_zero[i] = ~(|result[i*CHUNK +: CHUNK]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero1  <= '0;
            msb1   <= 1'b0;
            carry1 <= 1'b0;
            ovf1   <= 1'b0;
            valid1 <= 1'b0;
            set1   <= 1'b0;
        end else if (flush) begin
            // flush beats stall: the held entry dies and the incoming one is dropped
            valid1 <= 1'b0;
            set1   <= 1'b0;
        end else if (!stall) begin
            zero1  <= slice_zero;
            msb1   <= result[WIDTH-1];
            carry1 <= carry_in;
            ovf1   <= overflow_in;
            valid1 <= in_valid;
            set1   <= set_flags;
        end
    end

    always_comb begin
        z_flag     = &zero1;
        next_flags = {msb1, z_flag, ovf1, carry1};
        commit     = valid1 & set1 & ~stall & ~flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags        <= 4'b0000;
            flags_update <= 1'b0;
        end else begin
            flags_update <= commit;
            if (commit) begin
                flags <= next_flags;
            end
        end
    end

endmodule

// File: doc/flag_pipe_unit.md
FLAG_PIPE_UNIT -- requirements
Module: flag_pipe_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the ALU result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, giving the width of each zero-detect slice; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: result, carry_in and overflow_in hold a valid ALU output this cycle.
REQ-006 SHALL have port set_flags, input, 1 bit: the instruction writes flags (flag-setting opcode); sampled with in_valid.
REQ-007 SHALL have port result, input, WIDTH bits: the ALU result.
REQ-008 SHALL have port carry_in, input, 1 bit: the ALU carry-out.
REQ-009 SHALL have port overflow_in, input, 1 bit: the ALU signed overflow.
REQ-010 SHALL have port stall, input, 1 bit: freeze both pipeline stages.
REQ-011 SHALL have port flush, input, 1 bit: kill in-flight, uncommitted flag updates.
REQ-012 SHALL have port flags, output, 4 bits: the architectural flags {N,Z,V,C}, bit 3 = N.
REQ-013 SHALL have port flags_update, output, 1 bit: one-cycle pulse when flags changed source this cycle.

Function
REQ-014 Stage 1 SHALL, on an edge with stall=0 and flush=0, register NCHUNK per-slice NOR results of result, result[WIDTH-1], carry_in, overflow_in, valid1 = in_valid and set1 = set_flags.
REQ-015 Stage 2 SHALL compute Z as the AND of all NCHUNK slice bits, with N = registered MSB, C = registered carry and V = registered overflow.
REQ-016 The flags register SHALL load {N,Z,V,C} on an edge where valid1=1, set1=1, stall=0 and flush=0; otherwise it SHALL hold.
REQ-017 Latency: inputs sampled at edge k SHALL appear on flags after edge k+1, with flags_update=1 for exactly the cycle following edge k+1.
REQ-018 An entry with in_valid=1 and set_flags=0 SHALL traverse the pipeline and SHALL NOT alter flags or pulse flags_update.
REQ-019 stall=1 SHALL hold stage 1, the flags register and flags_update=0, and SHALL ignore in_valid; no entry is lost or duplicated.
REQ-020 flush=1 SHALL have priority over stall: at that edge valid1 SHALL clear, the stage-1 entry SHALL NOT commit, and the current in_valid SHALL be discarded.
REQ-021 flush SHALL NOT alter already-committed flags.
REQ-022 Back-to-back valid flag-setting inputs on consecutive cycles SHALL each commit in order, one per cycle, with flags_update held high across consecutive commits.
REQ-023 The zero result SHALL be exact for all WIDTH bits; any single set bit in any slice SHALL give Z=0.

Reset
REQ-024 reset=0 SHALL immediately, without waiting for clk, clear flags to 4'b0000, flags_update to 0, valid1 and set1 to 0, and all stage-1 data to 0.
REQ-025 After reset deasserts, the first commit SHALL follow REQ-017 timing, with no spurious flags_update.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight stage-1 entry.

Verification
REQ-027 Zero result: result=0, carry_in=1, in_valid=1, set_flags=1 at edge k -> flags=4'b0101 after edge k+1, flags_update pulse of 1 cycle.
REQ-028 Negative plus overflow: result=64'h8000_0000_0000_0000, overflow_in=1, carry_in=0 -> flags=4'b1010; then result=64'h0000_0000_0001_0000, set_flags=0 -> flags unchanged, no pulse.
REQ-029 Slice coverage: a walking single 1 through bits 0..63, each flag-setting -> Z=0 every time; a following result=0 -> Z=1.
REQ-030 Stall: stall=1 for 3 cycles with a valid entry in stage 1 -> flags frozen and no pulse; the commit lands on the first edge after stall drops.
REQ-031 Flush with stall both high and a valid flag-setting entry in stage 1 -> no commit, flags retain prior value, no pulse.
REQ-032 Async reset: drop reset between edges with flags=4'b1111 -> flags=0 immediately; release reset and send result=0 -> flags=4'b0100 two edges later.
